class_vector_packer: RTL

//  Assembles the 10-element score vector for the argmax classifier from a serial stream of accumulator words.

---
 rtl/class_vector_packer_pkg.sv | 14 +
 rtl/class_vector_packer_score_narrow.sv | 30 +++
 rtl/class_vector_packer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/class_vector_packer_pkg.sv
// Shared constants, issue-FSM states and the pad-value helper for the score vector packer.
package class_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} issue_state_t;

  // Most negative signed value of the given width (low dw bits); padded slots can never win argmax.
  function automatic logic [31:0] pad_value(input int dw);
    return 32'hFFFF_FFFF << (dw - 1);
  endfunction

endpackage

// File: rtl/class_vector_packer_score_narrow.sv
// Combinational ACC_WIDTH -> DATA_WIDTH signed narrowing of one accumulator word.
// Define CLASS_PACKER_SATURATE_EN to clamp instead of wrapping.
module score_narrow #(
  parameter int ACC_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  output logic [DATA_WIDTH-1:0] o_data
);

`ifdef CLASS_PACKER_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  always_comb begin
    o_data = i_acc[DATA_WIDTH-1:0];
    if ($signed(i_acc) > $signed(MAX_V))
      o_data = MAX_V[DATA_WIDTH-1:0];
    else if ($signed(i_acc) < $signed(MIN_V))
      o_data = MIN_V[DATA_WIDTH-1:0];
  end
`else
  // Upper bits are simply discarded in wrap mode.
  logic w_unused_hi;
  assign w_unused_hi = ^i_acc;
  assign o_data      = i_acc[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/class_vector_packer.sv
// Double-buffered 10-element score packer feeding the argmax classifier with a start pulse.
// Narrowing clamps when CLASS_PACKER_SATURATE_EN is defined, wraps otherwise.
module class_vector_packer
  import class_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    clear,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [ACC_WIDTH-1:0]                    in_data,
  input  logic                                    in_last,
  output logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0]  matrix,
  output logic                                    start,
  input  logic                                    cls_ready,
  output logic                                    cls_busy,
  output logic                                    len_err
);

  localparam logic [31:0]           PAD_WIDE = pad_value(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PAD      = PAD_WIDE[DATA_WIDTH-1:0];
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] r_shadow;
  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] r_matrix;
  logic [IDX_W-1:0]                       r_idx;
  logic                                   r_full;
  logic                                   r_len_err;
  logic                                   r_wait_armed;
  issue_state_t                           r_state;
  issue_state_t                           w_state_nxt;

  logic [DATA_WIDTH-1:0] w_narrow;
  logic                  w_accept;
  logic                  w_at_end;
  logic                  w_close;
  logic                  w_copy;

  score_narrow #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_narrow (
    .i_acc  (in_data),
    .o_data (w_narrow)
  );

  // clear outranks a same-cycle accept and a pending copy.
  assign w_accept = in_valid & ~r_full & ~clear;
  assign w_at_end = (r_idx == LAST_IDX);
  assign w_close  = w_accept & (w_at_end | in_last);
  assign w_copy   = (r_state == IDLE) & r_full & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (IDX_W'(i) == r_idx)
          r_shadow[i] <= w_narrow;
        else if (in_last && (IDX_W'(i) > r_idx))
          r_shadow[i] <= PAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_full    <= 1'b0;
      r_len_err <= 1'b0;
    end else if (clear) begin
      r_idx     <= '0;
      r_full    <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      // Length error: closed by in_last early, or by the 10th word without in_last.
      r_len_err <= w_close & (w_at_end ^ in_last);
      if (w_close) begin
        r_idx  <= '0;
        r_full <= 1'b1;
      end else begin
        if (w_accept) r_idx  <= r_idx + IDX_W'(1);
        if (w_copy)   r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wait_armed <= 1'b0;
    end else if (clear) begin
      r_state      <= IDLE;
      r_wait_armed <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Low in the first WAIT cycle so a stale cls_ready level is not taken as a new result.
      r_wait_armed <= (r_state == WAIT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_full) w_state_nxt = FIRE;
      FIRE:    w_state_nxt = WAIT;
      WAIT:    if (r_wait_armed && cls_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_matrix <= '0;
    else if (w_copy) r_matrix <= r_shadow;
  end

  assign matrix   = r_matrix;
  assign in_ready = ~r_full;
  assign start    = (r_state == FIRE);
  assign cls_busy = (r_state != IDLE);
  assign len_err  = r_len_err;

endmodule
